// File: rtl/nn_pcpi_dot_master.sv
// nn_pcpi_dot_master: PCPI dot-product coprocessor for the FCN path.
// Decodes custom-0 instructions, streams weight/input words over the
// coprocessor memory port and returns the signed dot product in rd.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a matching custom-0 instruction
// START  | clear accumulator and element counter, skip empty vectors
// REQ_W  | read request for the weight word at pw
// GAP_W  | request dropped; absorbs the responder's trailing ready
// REQ_X  | read request for the input word at px
// GAP_X  | multiply-accumulate, advance element counter
// FINISH | one-cycle pcpi_ready/pcpi_wr pulse with the result
// HOLD   | one dead cycle so the CPU's lingering valid cannot retrigger

module nn_pcpi_dot_master #(
    parameter int LEN_DEFAULT = 784,
    parameter int LEN_W       = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pcpi_valid_i,
    input  logic [31:0] pcpi_insn_i,
    input  logic [31:0] pcpi_rs1_i,
    input  logic [31:0] pcpi_rs2_i,
    output logic        pcpi_wr_o,
    output logic [31:0] pcpi_rd_o,
    output logic        pcpi_wait_o,
    output logic        pcpi_ready_o,
    output logic        mem_valid_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    typedef enum logic [2:0] {
        IDLE, START, REQ_W, GAP_W, REQ_X, GAP_X, FINISH, HOLD
    } state_t;

    state_t           state_q;
    logic [31:0]      pw_q, px_q, w_q, x_q, acc_q;
    logic [LEN_W-1:0] cnt_q, len_q;
    logic             relu_q;
    logic             pcpi_wr_q, pcpi_wait_q, pcpi_ready_q, mem_valid_q;
    logic [31:0]      pcpi_rd_q, mem_addr_q;

    logic        insn_match;
    logic        is_dot, is_dotr, is_setlen;
    logic [31:0] prod_d, acc_d;
    logic        last_elem;

    // Instruction decode and datapath helpers
    assign insn_match = pcpi_valid_i && (pcpi_insn_i[6:0] == 7'b0001011)
                        && (pcpi_insn_i[14:12] == 3'b000);
    assign is_dot     = insn_match && (pcpi_insn_i[31:25] == 7'b0000001);
    assign is_dotr    = insn_match && (pcpi_insn_i[31:25] == 7'b0000011);
    assign is_setlen  = insn_match && (pcpi_insn_i[31:25] == 7'b0000010);

    // Low 32 bits of a product are the same for signed and unsigned operands
    assign prod_d    = w_q * x_q;
    assign acc_d     = acc_q + prod_d;
    assign last_elem = (cnt_q == len_q - 1'b1);

    // Sequencer: state, datapath registers and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            pw_q         <= '0;
            px_q         <= '0;
            w_q          <= '0;
            x_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            len_q        <= LEN_W'(LEN_DEFAULT);
            relu_q       <= 1'b0;
            pcpi_wr_q    <= 1'b0;
            pcpi_wait_q  <= 1'b0;
            pcpi_ready_q <= 1'b0;
            pcpi_rd_q    <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            pcpi_ready_q <= 1'b0;
            pcpi_wr_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_dot || is_dotr) begin
                        pw_q        <= pcpi_rs1_i;
                        px_q        <= pcpi_rs2_i;
                        relu_q      <= is_dotr;
                        pcpi_wait_q <= 1'b1;
                        state_q     <= START;
                    end else if (is_setlen) begin
                        len_q        <= pcpi_rs1_i[LEN_W-1:0];
                        pcpi_rd_q    <= 32'(len_q);
                        pcpi_ready_q <= 1'b1;
                        pcpi_wr_q    <= 1'b1;
                        state_q      <= FINISH;
                    end
                end
                START: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (len_q == '0) begin
                        pcpi_rd_q    <= '0;
                        pcpi_ready_q <= 1'b1;
                        pcpi_wr_q    <= 1'b1;
                        pcpi_wait_q  <= 1'b0;
                        state_q      <= FINISH;
                    end else begin
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= pw_q;
                        state_q     <= REQ_W;
                    end
                end
                REQ_W: begin
                    if (mem_ready_i) begin
                        w_q         <= mem_rdata_i;
                        pw_q        <= pw_q + 32'd4;
                        mem_valid_q <= 1'b0;
                        state_q     <= GAP_W;
                    end
                end
                GAP_W: begin
                    mem_valid_q <= 1'b1;
                    mem_addr_q  <= px_q;
                    state_q     <= REQ_X;
                end
                REQ_X: begin
                    if (mem_ready_i) begin
                        x_q         <= mem_rdata_i;
                        px_q        <= px_q + 32'd4;
                        mem_valid_q <= 1'b0;
                        state_q     <= GAP_X;
                    end
                end
                GAP_X: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_elem) begin
                        pcpi_rd_q    <= (relu_q && acc_d[31]) ? 32'd0 : acc_d;
                        pcpi_ready_q <= 1'b1;
                        pcpi_wr_q    <= 1'b1;
                        pcpi_wait_q  <= 1'b0;
                        state_q      <= FINISH;
                    end else begin
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= pw_q;
                        state_q     <= REQ_W;
                    end
                end
                FINISH: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pcpi_wr_o    = pcpi_wr_q;
    assign pcpi_rd_o    = pcpi_rd_q;
    assign pcpi_wait_o  = pcpi_wait_q;
    assign pcpi_ready_o = pcpi_ready_q;
    assign mem_valid_o  = mem_valid_q;
    assign mem_write_o  = 1'b0;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = '0;

endmodule

// File: tb/tb_nn_pcpi_dot_master.sv
// Directed bench for nn_pcpi_dot_master with a behavioural memory responder.
module tb_nn_pcpi_dot_master;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        pcpi_valid_i;
    logic [31:0] pcpi_insn_i, pcpi_rs1_i, pcpi_rs2_i;
    logic        pcpi_wr_o, pcpi_wait_o, pcpi_ready_o;
    logic [31:0] pcpi_rd_o;
    logic        mem_valid_o, mem_write_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    nn_pcpi_dot_master #(.LEN_DEFAULT(784), .LEN_W(16)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .pcpi_valid_i (pcpi_valid_i),
        .pcpi_insn_i  (pcpi_insn_i),
        .pcpi_rs1_i   (pcpi_rs1_i),
        .pcpi_rs2_i   (pcpi_rs2_i),
        .pcpi_wr_o    (pcpi_wr_o),
        .pcpi_rd_o    (pcpi_rd_o),
        .pcpi_wait_o  (pcpi_wait_o),
        .pcpi_ready_o (pcpi_ready_o),
        .mem_valid_o  (mem_valid_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Responder state
    logic [31:0] mem [logic [31:0]];
    logic [31:0] alog [$];
    int          nreads    = 0;
    int          hold_err  = 0;
    int          delay_read = 0;
    int          trail_read = 0;
    int          rphase    = 0;
    int          dly       = 0;
    logic [31:0] req_addr  = '0;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'd0;
    endfunction

    // Responder: answers one cycle after it sees a request, with optional
    // extra stall and an optional trailing ready during the gap cycle.
    initial begin
        logic        v;
        logic [31:0] a;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            v = mem_valid_o;
            a = mem_addr_o;
            @(posedge clk_i);
            #2;
            if (reset_i) begin
                mem_ready_i = 1'b0;
                rphase      = 0;
            end else begin
                case (rphase)
                    0: if (v) begin
                        nreads++;
                        req_addr = a;
                        alog.push_back(a);
                        dly = (nreads == delay_read) ? 4 : 0;
                        if (dly == 0) begin
                            mem_ready_i = 1'b1;
                            mem_rdata_i = rd_mem(req_addr);
                            rphase      = 2;
                        end else begin
                            rphase = 1;
                        end
                    end
                    1: begin
                        if (!v || a != req_addr) hold_err++;
                        dly--;
                        if (dly == 0) begin
                            mem_ready_i = 1'b1;
                            mem_rdata_i = rd_mem(req_addr);
                            rphase      = 2;
                        end
                    end
                    2: begin
                        if (!v || a != req_addr) hold_err++;
                        if (trail_read == nreads) begin
                            mem_rdata_i = 32'hDEAD_BEEF;
                            rphase      = 3;
                        end else begin
                            mem_ready_i = 1'b0;
                            rphase      = 0;
                        end
                    end
                    default: begin
                        mem_ready_i = 1'b0;
                        rphase      = 0;
                    end
                endcase
            end
        end
    end

    localparam logic [6:0] F7_DOT    = 7'b0000001;
    localparam logic [6:0] F7_DOTR   = 7'b0000011;
    localparam logic [6:0] F7_SETLEN = 7'b0000010;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [6:0] op);
        return {f7, 10'd0, 3'b000, 5'd0, op};
    endfunction

    // Issue one instruction; cyc counts edges from presenting valid to ready.
    // valid stays high through FINISH and HOLD like a slow CPU would.
    task automatic issue(input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                         output int cyc, output logic [31:0] rd, output logic wr);
        cyc = -1;
        rd  = '0;
        wr  = 1'b0;
        pcpi_insn_i  = mk(f7, 7'b0001011);
        pcpi_rs1_i   = rs1;
        pcpi_rs2_i   = rs2;
        pcpi_valid_i = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk_i);
            #1;
            if (pcpi_ready_o) begin
                cyc = n;
                rd  = pcpi_rd_o;
                wr  = pcpi_wr_o;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        pcpi_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("no_retrigger", {30'd0, pcpi_wait_o, pcpi_ready_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [31:0] rd;
        logic        wr;
        int          r0;
        int          pulses;

        reset_i      = 1'b1;
        pcpi_valid_i = 1'b0;
        pcpi_insn_i  = '0;
        pcpi_rs1_i   = '0;
        pcpi_rs2_i   = '0;
        mem[32'h10000] = 32'd2;
        mem[32'h10004] = 32'hFFFF_FFFD;
        mem[32'h10008] = 32'd4;
        mem[32'h20000] = 32'd5;
        mem[32'h20004] = 32'd6;
        mem[32'h20008] = 32'hFFFF_FFFF;
        mem[32'h30000] = 32'h0001_0000;
        mem[32'h30004] = 32'd5;
        mem[32'h40000] = 32'h0001_0000;
        mem[32'h40004] = 32'd7;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", {31'd0, pcpi_ready_o}, 32'd0);
        chk("rst_wait",  {31'd0, pcpi_wait_o},  32'd0);
        chk("rst_wr",    {31'd0, pcpi_wr_o},    32'd0);
        chk("rst_rd",    pcpi_rd_o,             32'd0);
        chk("rst_mvalid", {31'd0, mem_valid_o}, 32'd0);
        chk("rst_maddr", mem_addr_o,            32'd0);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        issue(F7_SETLEN, 32'd3, 32'd0, cyc, rd, wr);
        chk("setlen_cyc", 32'(cyc), 32'd1);
        chk("setlen_rd",  rd,       32'd784);
        chk("setlen_wr",  {31'd0, wr}, 32'd1);

        alog.delete();
        issue(F7_DOT, 32'h10000, 32'h20000, cyc, rd, wr);
        chk("dot_cyc", 32'(cyc), 32'd20);
        chk("dot_rd",  rd,       32'hFFFF_FFF4);
        chk("dot_wr",  {31'd0, wr}, 32'd1);
        chk("dot_nreq", 32'(alog.size()), 32'd6);
        if (alog.size() == 6) begin
            chk("addr0", alog[0], 32'h10000);
            chk("addr1", alog[1], 32'h20000);
            chk("addr2", alog[2], 32'h10004);
            chk("addr3", alog[3], 32'h20004);
            chk("addr4", alog[4], 32'h10008);
            chk("addr5", alog[5], 32'h20008);
        end
        repeat (3) @(posedge clk_i);
        #1;
        chk("rd_held", pcpi_rd_o, 32'hFFFF_FFF4);

        issue(F7_DOTR, 32'h10000, 32'h20000, cyc, rd, wr);
        chk("dotr_neg12", rd, 32'd0);
        mem[32'h20008] = 32'd1;
        issue(F7_DOTR, 32'h10000, 32'h20000, cyc, rd, wr);
        chk("dotr_neg4", rd, 32'd0);
        issue(F7_DOT, 32'h10000, 32'h20000, cyc, rd, wr);
        chk("dot_neg4", rd, 32'hFFFF_FFFC);
        mem[32'h10004] = 32'd3;
        issue(F7_DOTR, 32'h10000, 32'h20000, cyc, rd, wr);
        chk("dotr_pos32", rd, 32'd32);

        // Stalled second read plus a trailing ready during GAP_W
        alog.delete();
        hold_err   = 0;
        delay_read = nreads + 2;
        trail_read = nreads + 1;
        issue(F7_DOT, 32'h10000, 32'h20000, cyc, rd, wr);
        delay_read = 0;
        trail_read = 0;
        chk("stall_rd",   rd,       32'd32);
        chk("stall_cyc",  32'(cyc), 32'd24);
        chk("stall_hold", 32'(hold_err), 32'd0);
        chk("stall_nreq", 32'(alog.size()), 32'd6);
        if (alog.size() >= 2) chk("stall_addr1", alog[1], 32'h20000);

        // Product truncation: 0x10000*0x10000 wraps to 0
        issue(F7_SETLEN, 32'd2, 32'd0, cyc, rd, wr);
        chk("setlen2_rd", rd, 32'd3);
        issue(F7_DOT, 32'h30000, 32'h40000, cyc, rd, wr);
        chk("wrap_rd",  rd,       32'd35);
        chk("wrap_cyc", 32'(cyc), 32'd14);

        // Empty vector
        issue(F7_SETLEN, 32'd0, 32'd0, cyc, rd, wr);
        chk("setlen0_rd", rd, 32'd2);
        r0 = nreads;
        issue(F7_DOT, 32'h10000, 32'h20000, cyc, rd, wr);
        chk("len0_cyc",  32'(cyc), 32'd2);
        chk("len0_rd",   rd,       32'd0);
        chk("len0_nreq", 32'(nreads - r0), 32'd0);

        // Reset during REQ_X of element 2
        issue(F7_SETLEN, 32'd3, 32'd0, cyc, rd, wr);
        chk("setlen3_rd", rd, 32'd0);
        pcpi_insn_i  = mk(F7_DOT, 7'b0001011);
        pcpi_rs1_i   = 32'h10000;
        pcpi_rs2_i   = 32'h20000;
        pcpi_valid_i = 1'b1;
        cyc = -1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk_i);
            #1;
            if (mem_valid_o && mem_addr_o == 32'h20004) begin
                cyc = n;
                break;
            end
        end
        chk("abort_reached", {31'd0, cyc >= 0}, 32'd1);
        pcpi_valid_i = 1'b0;
        reset_i      = 1'b1;
        @(posedge clk_i);
        #1;
        chk("abort_mvalid", {31'd0, mem_valid_o}, 32'd0);
        chk("abort_wait",   {31'd0, pcpi_wait_o}, 32'd0);
        reset_i = 1'b0;
        pulses  = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk_i);
            #1;
            if (pcpi_ready_o || pcpi_wait_o || mem_valid_o) pulses++;
        end
        chk("abort_quiet", 32'(pulses), 32'd0);
        issue(F7_SETLEN, 32'd3, 32'd0, cyc, rd, wr);
        chk("abort_len", rd, 32'd784);

        // Unknown funct7 and wrong opcode: never acknowledged
        pulses = 0;
        r0     = nreads;
        pcpi_insn_i  = mk(7'b0000100, 7'b0001011);
        pcpi_valid_i = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk_i);
            #1;
            if (pcpi_ready_o || pcpi_wait_o) pulses++;
        end
        pcpi_insn_i = mk(F7_DOT, 7'b0110011);
        for (int n = 0; n < 12; n++) begin
            @(posedge clk_i);
            #1;
            if (pcpi_ready_o || pcpi_wait_o) pulses++;
        end
        pcpi_valid_i = 1'b0;
        chk("unknown_quiet", 32'(pulses), 32'd0);
        chk("unknown_nreq",  32'(nreads - r0), 32'd0);
        chk("mem_write", {31'd0, mem_write_o}, 32'd0);
        chk("mem_wdata", mem_wdata_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
